// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : shared AES-128 constants, FSM states and GF(2^8) helpers    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int ROUND_W = 4;
  localparam int NR      = 10;

  localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NR);
  localparam logic [BLOCK_W-1:0] DEFAULT_KEY = 128'h00112233445566778899aabbccddeeff;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse is a^254 = product of a^(2^k), k=1..7; zero maps to zero naturally.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [BLOCK_W-1:0] key_step(input logic [BLOCK_W-1:0] k,
                                                 input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_round_ctrl_if : plaintext-in / ciphertext-out valid-ready bundle  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic               iIN_VALID;
  logic               oIN_READY;
  logic [BLOCK_W-1:0] iIN_DATA;
  logic               oOUT_VALID;
  logic               iOUT_READY;
  logic [BLOCK_W-1:0] oOUT_DATA;

  modport master (
    output iIN_VALID, iIN_DATA, iOUT_READY,
    input  oIN_READY, oOUT_VALID, oOUT_DATA
  );

  modport slave (
    input  iIN_VALID, iIN_DATA, iOUT_READY,
    output oIN_READY, oOUT_VALID, oOUT_DATA
  );

endinterface
`default_nettype wire

// File: rtl/aes_encode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_encode : one combinational AES-128 encryption round               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module aes_encode
  import aes_pkg::*;
(
  input  logic [ROUND_W-1:0] round_number,
  input  logic [BLOCK_W-1:0] data_block,
  input  logic [BLOCK_W-1:0] round_key,
  output logic [BLOCK_W-1:0] result_block
);

  logic [7:0]         w_sb [16];
  logic [7:0]         w_sr [16];
  logic [7:0]         w_mc [16];
  logic [BLOCK_W-1:0] w_shift_blk;
  logic [BLOCK_W-1:0] w_mix_blk;

  // Byte n sits at row n%4, column n/4 of the state matrix.
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      w_sb[n] = sbox(data_block[127-8*n -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[r+4*c] = w_sb[r+4*((c+r)%4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mc[4*c+0] = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^
                    w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^
                    w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^
                    xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc[4*c+3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^
                    w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
    end
    w_shift_blk = '0;
    w_mix_blk   = '0;
    for (int n = 0; n < 16; n++) begin
      w_shift_blk[127-8*n -: 8] = w_sr[n];
      w_mix_blk[127-8*n -: 8]   = w_mc[n];
    end
    if (round_number == '0) begin
      result_block = data_block ^ round_key;
    end else if (round_number == LAST_ROUND) begin
      result_block = w_shift_blk ^ round_key;
    end else begin
      result_block = w_mix_blk ^ round_key;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keygen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keygen : combinational AES-128 round key for a given round number     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module keygen
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] cipher_key,
  input  logic [ROUND_W-1:0] round_number,
  output logic [BLOCK_W-1:0] round_key
);

  logic [BLOCK_W-1:0] w_k;
  logic [7:0]         w_rcon;

  // Unrolled expansion; the round selected by round_number is tapped out.
  always_comb begin
    w_k       = cipher_key;
    w_rcon    = 8'h01;
    round_key = cipher_key;
    for (int i = 1; i <= NR; i++) begin
      w_k    = key_step(w_k, w_rcon);
      w_rcon = xtime(w_rcon);
      if (round_number == ROUND_W'(i)) round_key = w_k;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_round_ctrl : single-clock round sequencer for AES-128 encryption  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [BLOCK_W-1:0] iKEY,
  input  logic               iKEY_LD,
  aes_round_ctrl_if.slave    bus,
  output logic               oBUSY,
  output logic [BLOCK_W-1:0] oCIPHER_KEY,
  output logic [ROUND_W-1:0] oROUND,
  output logic [BLOCK_W-1:0] oSTATE_BLOCK,
  input  logic [BLOCK_W-1:0] iRESULT
);

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [BLOCK_W-1:0] out_q, out_d;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      round_q <= '0;
      key_q   <= DEFAULT_KEY;
      block_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      key_q   <= key_d;
      block_q <= block_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;
    block_d = block_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        // Key load lands on the same edge as accept, so a coincident load applies to this block.
        if (iKEY_LD) key_d = iKEY;
        if (bus.iIN_VALID) begin
          block_d = bus.iIN_DATA;
          round_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (round_q < LAST_ROUND) begin
          block_d = iRESULT;
          round_d = round_q + 4'd1;
        end else begin
          out_d   = iRESULT;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.iOUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.oIN_READY  = (state_q == IDLE);
  assign bus.oOUT_VALID = (state_q == DONE);
  assign bus.oOUT_DATA  = out_q;
  assign oBUSY          = (state_q == RUN);
  assign oCIPHER_KEY    = key_q;
  assign oROUND         = round_q;
  assign oSTATE_BLOCK   = block_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_aes_round_ctrl : directed FIPS-197 vectors through ctrl+datapath   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_ld;
  logic         busy;
  logic [127:0] cipher_key;
  logic [3:0]   round;
  logic [127:0] state_block;
  logic [127:0] round_key;
  logic [127:0] result;

  int checks   = 0;
  int failures = 0;

  aes_round_ctrl_if bus ();

  aes_round_ctrl dut (
    .iCLK         (clk),
    .iRST         (rst),
    .iKEY         (key_in),
    .iKEY_LD      (key_ld),
    .bus          (bus),
    .oBUSY        (busy),
    .oCIPHER_KEY  (cipher_key),
    .oROUND       (round),
    .oSTATE_BLOCK (state_block),
    .iRESULT      (result)
  );

  keygen u_keygen (
    .cipher_key   (cipher_key),
    .round_number (round),
    .round_key    (round_key)
  );

  aes_encode u_encode (
    .round_number (round),
    .data_block   (state_block),
    .round_key    (round_key),
    .result_block (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a block (optionally with a key load) for one edge; returns just after the accept edge.
  task automatic accept(input logic ld, input logic [127:0] k, input logic [127:0] pt);
    key_ld        = ld;
    key_in        = k;
    bus.iIN_VALID = 1'b1;
    bus.iIN_DATA  = pt;
    tick();
    key_ld        = 1'b0;
    bus.iIN_VALID = 1'b0;
  endtask

  // Walks rounds 0..NR; optionally pulses a key load at round ld_at. Returns after edge E0+NR+1.
  task automatic run_rounds(input string tag, input logic [127:0] pt, input logic [127:0] k,
                            input int ld_at, input logic [127:0] alt);
    for (int i = 0; i <= NR; i++) begin
      check({tag, "_round"}, 128'(round), 128'(i));
      check({tag, "_busy"}, 128'(busy), 128'd1);
      check({tag, "_valid_low"}, 128'(bus.oOUT_VALID), 128'd0);
      check({tag, "_key"}, cipher_key, k);
      if (i == 0) check({tag, "_state0"}, state_block, pt);
      if (i == ld_at) begin
        key_ld = 1'b1;
        key_in = alt;
      end
      tick();
      key_ld = 1'b0;
    end
  endtask

  task automatic finish_block(input string tag, input logic [127:0] ct, input logic handshake);
    check({tag, "_valid"}, 128'(bus.oOUT_VALID), 128'd1);
    check({tag, "_data"}, bus.oOUT_DATA, ct);
    check({tag, "_busy_low"}, 128'(busy), 128'd0);
    check({tag, "_in_ready_low"}, 128'(bus.oIN_READY), 128'd0);
    if (handshake) begin
      tick();
      check({tag, "_valid_drop"}, 128'(bus.oOUT_VALID), 128'd0);
      check({tag, "_in_ready"}, 128'(bus.oIN_READY), 128'd1);
    end
  endtask

  initial begin
    rst            = 1'b1;
    key_in         = '0;
    key_ld         = 1'b0;
    bus.iIN_VALID  = 1'b0;
    bus.iIN_DATA   = '0;
    bus.iOUT_READY = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", 128'(bus.oIN_READY), 128'd1);
    check("rst_out_valid", 128'(bus.oOUT_VALID), 128'd0);
    check("rst_out_data", bus.oOUT_DATA, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_round", 128'(round), 128'd0);
    check("rst_state", state_block, 128'd0);
    check("rst_key", cipher_key, DEFAULT_KEY);

    // FIPS-197 C.1 with a separate key load
    key_ld = 1'b1;
    key_in = C1_KEY;
    tick();
    key_ld = 1'b0;
    check("c1_keyload", cipher_key, C1_KEY);
    accept(1'b0, '0, C1_PT);
    run_rounds("c1", C1_PT, C1_KEY, -1, '0);
    finish_block("c1", C1_CT, 1'b1);

    // FIPS-197 Appendix B
    key_ld = 1'b1;
    key_in = B_KEY;
    tick();
    key_ld = 1'b0;
    accept(1'b0, '0, B_PT);
    run_rounds("appb", B_PT, B_KEY, -1, '0);
    finish_block("appb", B_CT, 1'b1);

    // Load and accept on the same edge: C.1 key replaces B key for this block
    accept(1'b1, C1_KEY, C1_PT);
    run_rounds("simul", C1_PT, C1_KEY, -1, '0);
    finish_block("simul", C1_CT, 1'b1);

    // Backpressure with a competing plaintext held by the producer
    bus.iOUT_READY = 1'b0;
    accept(1'b0, '0, C1_PT);
    run_rounds("bp", C1_PT, C1_KEY, -1, '0);
    finish_block("bp", C1_CT, 1'b0);
    bus.iIN_VALID = 1'b1;
    bus.iIN_DATA  = C1_PT;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold_valid", 128'(bus.oOUT_VALID), 128'd1);
      check("bp_hold_data", bus.oOUT_DATA, C1_CT);
      check("bp_hold_in_ready", 128'(bus.oIN_READY), 128'd0);
      check("bp_hold_round", 128'(round), 128'd10);
    end
    bus.iOUT_READY = 1'b1;
    tick();
    check("bp_hs_valid", 128'(bus.oOUT_VALID), 128'd0);
    check("bp_hs_in_ready", 128'(bus.oIN_READY), 128'd1);
    check("bp_hs_busy", 128'(busy), 128'd0);
    tick();
    bus.iIN_VALID = 1'b0;
    run_rounds("bp2", C1_PT, C1_KEY, -1, '0);
    finish_block("bp2", C1_CT, 1'b1);

    // Key load pulsed mid-RUN must be ignored
    accept(1'b0, '0, C1_PT);
    run_rounds("busyld", C1_PT, C1_KEY, 3, B_KEY);
    finish_block("busyld", C1_CT, 1'b1);
    check("busyld_key_after", cipher_key, C1_KEY);

    // Reset at round 5 discards the block
    accept(1'b1, B_KEY, B_PT);
    for (int i = 0; i < 5; i++) tick();
    check("abort_round5", 128'(round), 128'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 128'(bus.oIN_READY), 128'd1);
    check("abort_valid", 128'(bus.oOUT_VALID), 128'd0);
    check("abort_key", cipher_key, DEFAULT_KEY);
    check("abort_round", 128'(round), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_state", state_block, 128'd0);
    check("abort_data", bus.oOUT_DATA, 128'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("abort_no_output", 128'(bus.oOUT_VALID), 128'd0);
    end
    accept(1'b1, C1_KEY, C1_PT);
    run_rounds("post", C1_PT, C1_KEY, -1, '0);
    finish_block("post", C1_CT, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
